// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and the packed decode field layout for D_out.
package rv32_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef enum logic [4:0] {
    OP_LOAD  = 5'b00000,
    OP_I     = 5'b00100,
    OP_AUIPC = 5'b00101,
    OP_S     = 5'b01000,
    OP_R     = 5'b01100,
    OP_LUI   = 5'b01101,
    OP_B     = 5'b11000,
    OP_JALR  = 5'b11001,
    OP_JAL   = 5'b11011
  } opcode_t;
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 5;
  localparam int F3_LSB  = 10;
  localparam int RS1_LSB = 13;
  localparam int RS2_LSB = 18;
  localparam int F7B_BIT = 23;
  localparam int DOUT_W  = 24;
endpackage

// File: rtl/fetch_decode_stage_if.sv
// fetch_decode_stage_if: instruction memory port between the fetch stage and memory.
interface fetch_decode_stage_if;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  modport master(output im_addr, input im_rdata);
  modport slave(input im_addr, output im_rdata);
endinterface

// File: rtl/dec_field_pack.sv
// dec_field_pack: packs the controller-relevant instruction fields into D_out.
module dec_field_pack
  import rv32_pkg::*;
(
  input  logic [31:0]       inst,
  output logic [DOUT_W-1:0] d_out
);
  logic unused;
  assign unused = ^{inst[31], inst[29:25], inst[1:0]};
  always_comb begin
    d_out = '0;
    d_out[OPC_LSB +: 5] = inst[6:2];
    d_out[RD_LSB +: 5]  = inst[11:7];
    d_out[F3_LSB +: 3]  = inst[14:12];
    d_out[RS1_LSB +: 5] = inst[19:15];
    d_out[RS2_LSB +: 5] = inst[24:20];
    d_out[F7B_BIT]      = inst[30];
  end
endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC register plus F/D pipeline register with redirect, stall and event counters.
module fetch_decode_stage
  import rv32_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      next_pc_sel,
  input  logic [31:0]               jb_target,
  fetch_decode_stage_if.master      im,
  output logic [31:0]               D_pc,
  output logic [31:0]               D_inst,
  output logic [DOUT_W-1:0]         D_out,
  output logic                      D_valid,
  output logic [15:0]               stall_cnt,
  output logic [15:0]               flush_cnt
);
  logic [31:0] f_pc;
  logic unused;
  assign unused = ^jb_target[1:0];
  assign im.im_addr = f_pc;
  // Redirect wins over stall; the squashed slot becomes a harmless addi x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc      <= RESET_PC;
      D_inst    <= NOP_INST;
      D_pc      <= '0;
      D_valid   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!next_pc_sel) begin
      f_pc      <= {jb_target[31:2], 2'b00};
      D_inst    <= NOP_INST;
      D_pc      <= '0;
      D_valid   <= 1'b0;
      flush_cnt <= flush_cnt + {15'd0, ~&flush_cnt};
    end else if (stall) begin
      stall_cnt <= stall_cnt + {15'd0, ~&stall_cnt};
    end else begin
      f_pc    <= f_pc + 32'd4;
      D_inst  <= im.im_rdata;
      D_pc    <= f_pc;
      D_valid <= 1'b1;
    end
  end
  dec_field_pack u_pack (.inst(D_inst), .d_out(D_out));
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: randomized and directed checks against a behavioural fetch/decode model.
module tb_fetch_decode_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        next_pc_sel = 1'b1;
  logic [31:0] jb_target = '0;
  logic [31:0] D_pc, D_inst;
  logic [23:0] D_out;
  logic        D_valid;
  logic [15:0] stall_cnt, flush_cnt;
  logic [31:0] mem [128];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_fpc, m_dinst, m_dpc;
  logic        m_dv;
  logic [15:0] m_sc, m_fc;

  fetch_decode_stage_if bus();
  assign bus.im_rdata = mem[bus.im_addr[8:2]];

  fetch_decode_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .next_pc_sel(next_pc_sel),
    .jb_target(jb_target), .im(bus.master), .D_pc(D_pc), .D_inst(D_inst),
    .D_out(D_out), .D_valid(D_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] fields(input logic [31:0] i);
    return {i[30], i[24:20], i[19:15], i[14:12], i[11:7], i[6:2]};
  endfunction

  task automatic step(input logic s, input logic sel, input logic [31:0] tgt, input logic r);
    stall = s; next_pc_sel = sel; jb_target = tgt; rst = r;
    @(posedge clk);
    if (r) begin
      m_fpc = 0; m_dinst = 32'h13; m_dpc = 0; m_dv = 0; m_sc = 0; m_fc = 0;
    end else if (!sel) begin
      m_fpc = tgt & ~32'd3; m_dinst = 32'h13; m_dpc = 0; m_dv = 0;
      if (m_fc != 16'hFFFF) m_fc++;
    end else if (s) begin
      if (m_sc != 16'hFFFF) m_sc++;
    end else begin
      m_dinst = mem[m_fpc[8:2]]; m_dpc = m_fpc; m_fpc = m_fpc + 4; m_dv = 1;
    end
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".im_addr"}, bus.im_addr, m_fpc);
    check({tag, ".D_pc"}, D_pc, m_dpc);
    check({tag, ".D_inst"}, D_inst, m_dinst);
    check({tag, ".D_out"}, {8'd0, D_out}, {8'd0, fields(m_dinst)});
    check({tag, ".D_valid"}, {31'd0, D_valid}, {31'd0, m_dv});
    check({tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, m_sc});
    check({tag, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, m_fc});
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093; mem[1] = 32'h00A0_0113; mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0000_A183; mem[64] = 32'h1234_5678;
    step(0, 1, 0, 1);
    compare_all("reset");
    check("reset.D_out", {8'd0, D_out}, 32'h0000_0004);
    step(0, 1, 0, 0); compare_all("adv0"); check("adv0.opc", {27'd0, D_out[4:0]}, 32'h04);
    check("adv0.D_pc", D_pc, 32'h0);
    step(0, 1, 0, 0); compare_all("adv1"); check("adv1.opc", {27'd0, D_out[4:0]}, 32'h04);
    step(0, 1, 0, 0); compare_all("adv2"); check("adv2.opc", {27'd0, D_out[4:0]}, 32'h0C);
    check("adv2.D_pc", D_pc, 32'h8);
    step(0, 1, 0, 0); check("ld.D_inst", D_inst, 32'h0000_A183);
    step(1, 1, 0, 0); compare_all("stall1");
    step(1, 1, 0, 0); compare_all("stall2");
    check("stall.cnt", {16'd0, stall_cnt}, 32'd2);
    check("stall.hold_pc", bus.im_addr, 32'h10);
    step(0, 1, 0, 0); compare_all("resume"); check("resume.D_pc", D_pc, 32'h10);
    repeat (3) step(0, 1, 0, 0);
    check("pre_redir.pc", bus.im_addr, 32'h20);
    step(0, 0, 32'h0000_0103, 0); compare_all("redir");
    check("redir.im_addr", bus.im_addr, 32'h100);
    check("redir.flush", {16'd0, flush_cnt}, 32'd1);
    step(0, 1, 0, 0); compare_all("tgt");
    check("tgt.D_inst", D_inst, 32'h1234_5678);
    step(1, 0, 32'h40, 0); compare_all("stall_redir");
    check("stall_redir.scnt", {16'd0, stall_cnt}, 32'd2);
    step(0, 0, 32'hFFFF_FFFE, 0); compare_all("to_top");
    step(0, 1, 0, 0); compare_all("wrap");
    check("wrap.im_addr", bus.im_addr, 32'h0);
    step(1, 0, 32'h80, 1); compare_all("rst_mid");
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) >= 15,
           {$urandom_range(0, 1) ? 32'hFFFF_FE00 : 32'h0, 23'd0, 9'($urandom)},
           $urandom_range(0, 99) < 2);
      compare_all("rand");
    end
    step(0, 1, 0, 1);
    for (int n = 0; n < 70000; n++) step(1, 1, 0, 0);
    compare_all("sat");
    check("sat.scnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    step(1, 1, 0, 0);
    check("sat.hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
